sharpen_window_gen: RTL and testbench

Streaming 3x3 neighbourhood generator placed directly upstream of the sharpen kernel. Accepts a raster-ordered 24-bit RGB pixel stream, one frame of V_SIZE x H_SIZE. Emits, for every pixel position, the 3x3 window centred on it, with out-of-image taps forced to 24'd0. Uses two line buffers, so the kernel no longer needs random access to a full frame buffer.

---
 rtl/sharpen_pkg.sv | 40 ++++
 rtl/sharpen_window_gen_if.sv | 22 ++
 rtl/sharpen_line_buffer.sv | 22 ++
 rtl/sharpen_window_gen.sv | 142 ++++++++++++++
 tb/tb_sharpen_window_gen.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sharpen_pkg.sv
// rtl/sharpen_pkg.sv - shared constants, tap indices and FSM states for the sharpen window generator
// Contents: PIX_W, default frame geometry, tap indices TAP_TL..TAP_BR (t = 3*row+col),
// state_t {PRIME, STREAM, FLUSH, DONE}, and border_mask() which returns a per-tap keep mask.
package sharpen_pkg;
   localparam int PIX_W      = 24;
   localparam int DEF_V_SIZE = 512;
   localparam int DEF_H_SIZE = 512;

   localparam int TAP_TL = 0;
   localparam int TAP_TC = 1;
   localparam int TAP_TR = 2;
   localparam int TAP_ML = 3;
   localparam int TAP_MC = 4;
   localparam int TAP_MR = 5;
   localparam int TAP_BL = 6;
   localparam int TAP_BC = 7;
   localparam int TAP_BR = 8;

   typedef enum logic [1:0] {PRIME, STREAM, FLUSH, DONE} state_t;

   // Bit t set means tap t lies inside the image; corners clear both edges.
   function automatic logic [8:0] border_mask(input logic top, input logic bottom,
                                              input logic left, input logic right);
      logic [8:0] keep;
      keep = 9'h1FF;
      if (top) begin
         keep[TAP_TL] = 1'b0; keep[TAP_TC] = 1'b0; keep[TAP_TR] = 1'b0;
      end
      if (bottom) begin
         keep[TAP_BL] = 1'b0; keep[TAP_BC] = 1'b0; keep[TAP_BR] = 1'b0;
      end
      if (left) begin
         keep[TAP_TL] = 1'b0; keep[TAP_ML] = 1'b0; keep[TAP_BL] = 1'b0;
      end
      if (right) begin
         keep[TAP_TR] = 1'b0; keep[TAP_MR] = 1'b0; keep[TAP_BR] = 1'b0;
      end
      return keep;
   endfunction
endpackage

// File: rtl/sharpen_window_gen_if.sv
// rtl/sharpen_window_gen_if.sv - pixel-in / window-out handshake bundle
// Signals: pix_in, pix_in_valid, pix_in_ready (pixel stream); win_data, win_row, win_col,
// win_valid, win_ready (window stream); frame_done (end-of-frame pulse).
// Modports: slave = the window generator, master = the surrounding source/sink.
interface sharpen_window_gen_if;
   import sharpen_pkg::*;

   logic [PIX_W-1:0]   pix_in;
   logic               pix_in_valid;
   logic               pix_in_ready;
   logic [9*PIX_W-1:0] win_data;
   logic [15:0]        win_row;
   logic [15:0]        win_col;
   logic               win_valid;
   logic               win_ready;
   logic               frame_done;

   modport master (output pix_in, pix_in_valid, win_ready,
                   input  pix_in_ready, win_data, win_row, win_col, win_valid, frame_done);
   modport slave  (input  pix_in, pix_in_valid, win_ready,
                   output pix_in_ready, win_data, win_row, win_col, win_valid, frame_done);
endinterface

// File: rtl/sharpen_line_buffer.sv
// rtl/sharpen_line_buffer.sv - one image row of pixel storage, read-before-write
// Ports: clk; en (write strobe / advance); addr (shared row position); din (pixel written);
// dout (pixel stored at addr one row earlier, valid before the write takes effect).
module sharpen_line_buffer import sharpen_pkg::*; #(
   parameter int DEPTH = DEF_H_SIZE,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             en,
   input  logic [AW-1:0]    addr,
   input  logic [PIX_W-1:0] din,
   output logic [PIX_W-1:0] dout
);
   // Contents are deliberately not reset; border masking hides stale entries.
   logic [PIX_W-1:0] mem [DEPTH];

   assign dout = mem[addr];

   always_ff @(posedge clk) begin
      if (en) mem[addr] <= din;
   end
endmodule

// File: rtl/sharpen_window_gen.sv
// rtl/sharpen_window_gen.sv - streaming 3x3 neighbourhood generator with border zeroing
// Ports: clk; reset (async, active-high); bus (sharpen_window_gen_if.slave) carrying the
// raster pixel stream in and the masked 3x3 window stream (+ centre row/col, frame_done) out.
module sharpen_window_gen import sharpen_pkg::*; #(
   parameter int V_SIZE = DEF_V_SIZE,
   parameter int H_SIZE = DEF_H_SIZE
) (
   input logic                 clk,
   input logic                 reset,
   sharpen_window_gen_if.slave bus
);
   localparam int NPIX  = V_SIZE * H_SIZE;
   localparam int CNT_W = $clog2(NPIX + 1);
   localparam int AW    = $clog2(H_SIZE);
   localparam int FW    = $clog2(H_SIZE + 2);

   state_t             state;
   logic [CNT_W-1:0]   in_cnt;
   logic [FW-1:0]      flush_cnt;
   logic [AW-1:0]      addr;
   logic [15:0]        ld_row, ld_col;   // coordinates of the next window to load
   logic [PIX_W-1:0]   taps [9];
   logic [PIX_W-1:0]   nxt  [9];
   logic [PIX_W-1:0]   lb1_out, lb2_out, new_pix;
   logic [9*PIX_W-1:0] win_load, win_data_r;
   logic [15:0]        win_row_r, win_col_r;
   logic               win_valid_r, frame_done_r;
   logic               out_free, pix_ready, in_take, flush_step, advance;
   logic [8:0]         keep;

   assign out_free   = !win_valid_r || bus.win_ready;
   assign in_take    = bus.pix_in_valid && pix_ready;
   assign flush_step = (state == FLUSH) && out_free && (flush_cnt != FW'(H_SIZE + 1));
   assign advance    = in_take || flush_step;
   assign new_pix    = (state == FLUSH) ? '0 : bus.pix_in;

   always_comb begin
      pix_ready = 1'b0;
      if (!reset) begin
         case (state)
            PRIME:   pix_ready = 1'b1;
            STREAM:  pix_ready = out_free;
            default: pix_ready = 1'b0;
         endcase
      end
   end

   // Window as it will look after this advance: shift left, new column on the right.
   always_comb begin
      for (int r = 0; r < 3; r++) begin
         nxt[3*r]     = taps[3*r+1];
         nxt[3*r + 1] = taps[3*r+2];
      end
      nxt[TAP_TR] = lb2_out;
      nxt[TAP_MR] = lb1_out;
      nxt[TAP_BR] = new_pix;
   end

   assign keep = border_mask(ld_row == 16'd0, ld_row == 16'(V_SIZE - 1),
                             ld_col == 16'd0, ld_col == 16'(H_SIZE - 1));

   always_comb begin
      win_load = '0;
      for (int t = 0; t < 9; t++)
         win_load[PIX_W*t +: PIX_W] = keep[t] ? nxt[t] : '0;
   end

   // Cascade: lb1 yields the pixel one row up, lb2 the pixel two rows up.
   sharpen_line_buffer #(.DEPTH(H_SIZE), .AW(AW)) u_lb1 (
      .clk(clk), .en(advance), .addr(addr), .din(new_pix), .dout(lb1_out));
   sharpen_line_buffer #(.DEPTH(H_SIZE), .AW(AW)) u_lb2 (
      .clk(clk), .en(advance), .addr(addr), .din(lb1_out), .dout(lb2_out));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= PRIME;
         in_cnt       <= '0;
         flush_cnt    <= '0;
         addr         <= '0;
         ld_row       <= '0;
         ld_col       <= '0;
         win_data_r   <= '0;
         win_row_r    <= '0;
         win_col_r    <= '0;
         win_valid_r  <= 1'b0;
         frame_done_r <= 1'b0;
         for (int t = 0; t < 9; t++) taps[t] <= '0;
      end else begin
         frame_done_r <= 1'b0;
         if (advance) begin
            for (int t = 0; t < 9; t++) taps[t] <= nxt[t];
            addr <= (addr == AW'(H_SIZE - 1)) ? '0 : addr + 1'b1;
         end
         if (in_take) in_cnt <= in_cnt + 1'b1;

         // Every advance after priming produces exactly one window.
         if (advance && state != PRIME) begin
            win_data_r  <= win_load;
            win_row_r   <= ld_row;
            win_col_r   <= ld_col;
            win_valid_r <= 1'b1;
            if (ld_col == 16'(H_SIZE - 1)) begin
               ld_col <= '0;
               ld_row <= ld_row + 1'b1;
            end else begin
               ld_col <= ld_col + 1'b1;
            end
         end else if (bus.win_ready) begin
            win_valid_r <= 1'b0;
         end

         case (state)
            PRIME:  if (in_take && in_cnt == CNT_W'(H_SIZE)) state <= STREAM;
            STREAM: if (in_take && in_cnt == CNT_W'(NPIX - 1)) state <= FLUSH;
            FLUSH: begin
               if (flush_step) begin
                  flush_cnt <= flush_cnt + 1'b1;
               end else if (flush_cnt == FW'(H_SIZE + 1) && win_valid_r && bus.win_ready) begin
                  state        <= DONE;
                  frame_done_r <= 1'b1;
               end
            end
            DONE: begin
               state     <= PRIME;
               in_cnt    <= '0;
               flush_cnt <= '0;
               addr      <= '0;
               ld_row    <= '0;
               ld_col    <= '0;
            end
            default: state <= PRIME;
         endcase
      end
   end

   assign bus.pix_in_ready = pix_ready;
   assign bus.win_data     = win_data_r;
   assign bus.win_row      = win_row_r;
   assign bus.win_col      = win_col_r;
   assign bus.win_valid    = win_valid_r;
   assign bus.frame_done   = frame_done_r;
endmodule

// File: tb/tb_sharpen_window_gen.sv
// tb/tb_sharpen_window_gen.sv - self-checking bench for sharpen_window_gen on a 4x4 frame
module tb_sharpen_window_gen;
   import sharpen_pkg::*;

   localparam int V = 4;
   localparam int H = 4;
   localparam int NPIX = V * H;
   localparam logic [PIX_W-1:0] WHITE = 24'hFFFFFF;

   logic clk = 1'b0;
   logic reset = 1'b1;

   sharpen_window_gen_if bus();

   sharpen_window_gen #(.V_SIZE(V), .H_SIZE(H)) dut (
      .clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int done_cnt = 0;
   int stall_err = 0;
   int first_idx;
   logic [9*PIX_W-1:0] win_q[$];
   logic [15:0] row_q[$];
   logic [15:0] col_q[$];
   logic prev_stall = 1'b0;
   logic [9*PIX_W+31:0] prev_snap = '0;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   // Monitor: captures transferred windows, counts frame_done, checks hold-under-stall.
   initial forever begin
      @(negedge clk);
      if (reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && (bus.win_valid !== 1'b1 ||
                            {bus.win_data, bus.win_row, bus.win_col} !== prev_snap))
            stall_err++;
         prev_stall = bus.win_valid && !bus.win_ready;
         prev_snap  = {bus.win_data, bus.win_row, bus.win_col};
         if (bus.win_valid && bus.win_ready) begin
            win_q.push_back(bus.win_data);
            row_q.push_back(bus.win_row);
            col_q.push_back(bus.win_col);
         end
         if (bus.frame_done) done_cnt++;
      end
   end

   function automatic logic [PIX_W-1:0] pix_at(input bit solid, input int r, input int c);
      if (r < 0 || r >= V || c < 0 || c >= H) return '0;
      return solid ? WHITE : PIX_W'(r * H + c);
   endfunction

   function automatic logic [9*PIX_W-1:0] model_win(input bit solid, input int r, input int c);
      logic [9*PIX_W-1:0] w;
      w = '0;
      for (int t = 0; t < 9; t++)
         w[PIX_W*t +: PIX_W] = pix_at(solid, r + t / 3 - 1, c + t % 3 - 1);
      return w;
   endfunction

   function automatic logic [9*PIX_W-1:0] pack9(input int v[9]);
      logic [9*PIX_W-1:0] w;
      w = '0;
      for (int t = 0; t < 9; t++) w[PIX_W*t +: PIX_W] = PIX_W'(v[t]);
      return w;
   endfunction

   function automatic logic [9*PIX_W-1:0] q_at(input int k);
      if (k < 0 || k >= win_q.size()) return 'x;
      return win_q[k];
   endfunction

   function automatic logic [15:0] row_at(input int k);
      if (k < 0 || k >= row_q.size()) return 'x;
      return row_q[k];
   endfunction

   function automatic logic [15:0] col_at(input int k);
      if (k < 0 || k >= col_q.size()) return 'x;
      return col_q[k];
   endfunction

   task automatic clear_q;
      win_q.delete();
      row_q.delete();
      col_q.delete();
   endtask

   // Drives count pixels; returns at the negedge that sees frame_done (wait_done) or once
   // the last pixel is committed to transfer at the next posedge (!wait_done).
   task automatic drive(input bit solid, input bit stall, input int count,
                        input bit wait_done, output bit timed_out);
      int idx;
      bit done;
      idx = 0;
      done = 1'b0;
      timed_out = 1'b1;
      first_idx = -1;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         @(posedge clk);
         #1;
         bus.win_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         if (idx < count) begin
            bus.pix_in_valid = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.pix_in = solid ? WHITE : PIX_W'(idx);
         end else begin
            bus.pix_in_valid = 1'b0;
         end
         @(negedge clk);
         if (first_idx < 0 && bus.win_valid) first_idx = idx;
         if (bus.pix_in_valid && bus.pix_in_ready) idx++;
         if (bus.frame_done) done = 1'b1;
         if ((wait_done && done) || (!wait_done && idx == count)) begin
            timed_out = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      n_vec++; if (bus.pix_in_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b need 0", bus.pix_in_ready); end
      n_vec++; if (bus.win_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b need 0", bus.win_valid); end
      n_vec++; if (bus.win_data !== '0) begin n_err++; $display("FAIL reset_data: got %h need 0", bus.win_data); end
      n_vec++; if (bus.win_row !== 16'd0 || bus.win_col !== 16'd0) begin n_err++; $display("FAIL reset_pos: got %0d,%0d need 0,0", bus.win_row, bus.win_col); end
      n_vec++; if (bus.frame_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b need 0", bus.frame_done); end
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      n_vec++; if (bus.pix_in_ready !== 1'b1) begin n_err++; $display("FAIL release_ready: got %b need 1", bus.pix_in_ready); end
      n_vec++; if (bus.win_valid !== 1'b0) begin n_err++; $display("FAIL release_valid: got %b need 0", bus.win_valid); end
   endtask

   task automatic test_basic;
      bit to;
      int d0;
      int v[9];
      clear_q();
      d0 = done_cnt;
      drive(1'b0, 1'b0, NPIX, 1'b1, to);
      @(negedge clk);
      n_vec++; if (to) begin n_err++; $display("FAIL basic_timeout: frame_done not seen, need it within budget"); end
      n_vec++; if (first_idx !== H + 2) begin n_err++; $display("FAIL basic_latency: first window after %0d pixels, need %0d", first_idx, H + 2); end
      n_vec++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL basic_frame_done: got %0d pulses need 1", done_cnt - d0); end
      n_vec++; if (win_q.size() !== NPIX) begin n_err++; $display("FAIL basic_count: got %0d windows need %0d", win_q.size(), NPIX); end
      for (int k = 0; k < NPIX; k++) begin
         n_vec++;
         if (row_at(k) !== 16'(k / H) || col_at(k) !== 16'(k % H) || q_at(k) !== model_win(1'b0, k / H, k % H)) begin
            n_err++;
            $display("FAIL basic_win%0d: got (%0d,%0d) %h need (%0d,%0d) %h", k, row_at(k), col_at(k), q_at(k), k / H, k % H, model_win(1'b0, k / H, k % H));
         end
      end
      v = '{0, 0, 0, 0, 0, 1, 0, 4, 5};
      n_vec++; if (q_at(0) !== pack9(v)) begin n_err++; $display("FAIL basic_tap00: got %h need %h", q_at(0), pack9(v)); end
      v = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
      n_vec++; if (q_at(5) !== pack9(v)) begin n_err++; $display("FAIL basic_tap11: got %h need %h", q_at(5), pack9(v)); end
      v = '{10, 11, 0, 14, 15, 0, 0, 0, 0};
      n_vec++; if (q_at(15) !== pack9(v)) begin n_err++; $display("FAIL basic_tap33: got %h need %h", q_at(15), pack9(v)); end
      n_vec++; if (bus.win_valid !== 1'b0 || bus.frame_done !== 1'b0) begin n_err++; $display("FAIL basic_idle: got valid %b done %b need 0 0", bus.win_valid, bus.frame_done); end
   endtask

   task automatic test_stall;
      bit to;
      int d0;
      clear_q();
      d0 = done_cnt;
      stall_err = 0;
      drive(1'b0, 1'b1, NPIX, 1'b1, to);
      @(negedge clk);
      n_vec++; if (to) begin n_err++; $display("FAIL stall_timeout: frame_done not seen, need it within budget"); end
      n_vec++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL stall_frame_done: got %0d pulses need 1", done_cnt - d0); end
      n_vec++; if (win_q.size() !== NPIX) begin n_err++; $display("FAIL stall_count: got %0d windows need %0d", win_q.size(), NPIX); end
      n_vec++; if (stall_err !== 0) begin n_err++; $display("FAIL stall_hold: %0d changes while stalled, need 0", stall_err); end
      for (int k = 0; k < NPIX; k++) begin
         n_vec++;
         if (row_at(k) !== 16'(k / H) || col_at(k) !== 16'(k % H) || q_at(k) !== model_win(1'b0, k / H, k % H)) begin
            n_err++;
            $display("FAIL stall_win%0d: got (%0d,%0d) %h need (%0d,%0d) %h", k, row_at(k), col_at(k), q_at(k), k / H, k % H, model_win(1'b0, k / H, k % H));
         end
      end
   endtask

   task automatic test_back_to_back;
      bit to1, to2;
      int d0;
      int v[9];
      clear_q();
      d0 = done_cnt;
      drive(1'b0, 1'b0, NPIX, 1'b1, to1);
      drive(1'b1, 1'b0, NPIX, 1'b1, to2);
      @(negedge clk);
      n_vec++; if (to1 || to2) begin n_err++; $display("FAIL b2b_timeout: got %b%b need 00", to1, to2); end
      n_vec++; if (done_cnt - d0 !== 2) begin n_err++; $display("FAIL b2b_frame_done: got %0d pulses need 2", done_cnt - d0); end
      n_vec++; if (win_q.size() !== 2 * NPIX) begin n_err++; $display("FAIL b2b_count: got %0d windows need %0d", win_q.size(), 2 * NPIX); end
      for (int k = 0; k < 2 * NPIX; k++) begin
         n_vec++;
         if (row_at(k) !== 16'((k % NPIX) / H) || col_at(k) !== 16'(k % H) ||
             q_at(k) !== model_win(k >= NPIX, (k % NPIX) / H, k % H)) begin
            n_err++;
            $display("FAIL b2b_win%0d: got (%0d,%0d) %h need (%0d,%0d) %h", k, row_at(k), col_at(k), q_at(k), (k % NPIX) / H, k % H, model_win(k >= NPIX, (k % NPIX) / H, k % H));
         end
      end
      v = '{0, 0, 0, 0, 'hFFFFFF, 'hFFFFFF, 0, 'hFFFFFF, 'hFFFFFF};
      n_vec++; if (q_at(NPIX) !== pack9(v)) begin n_err++; $display("FAIL b2b_tap00: got %h need %h", q_at(NPIX), pack9(v)); end
   endtask

   task automatic test_reset_mid;
      bit to;
      int d0;
      clear_q();
      drive(1'b0, 1'b0, 7, 1'b0, to);
      @(posedge clk);
      #1;
      bus.pix_in_valid = 1'b0;
      reset = 1'b1;
      #1;
      n_vec++; if (bus.win_valid !== 1'b0 || bus.pix_in_ready !== 1'b0) begin n_err++; $display("FAIL midreset_async: got valid %b ready %b need 0 0", bus.win_valid, bus.pix_in_ready); end
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      clear_q();
      d0 = done_cnt;
      drive(1'b0, 1'b0, NPIX, 1'b1, to);
      @(negedge clk);
      n_vec++; if (to) begin n_err++; $display("FAIL midreset_timeout: frame_done not seen, need it within budget"); end
      n_vec++; if (first_idx !== H + 2) begin n_err++; $display("FAIL midreset_latency: first window after %0d pixels, need %0d", first_idx, H + 2); end
      n_vec++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL midreset_frame_done: got %0d pulses need 1", done_cnt - d0); end
      n_vec++; if (win_q.size() !== NPIX) begin n_err++; $display("FAIL midreset_count: got %0d windows need %0d", win_q.size(), NPIX); end
      for (int k = 0; k < NPIX; k++) begin
         n_vec++;
         if (row_at(k) !== 16'(k / H) || col_at(k) !== 16'(k % H) || q_at(k) !== model_win(1'b0, k / H, k % H)) begin
            n_err++;
            $display("FAIL midreset_win%0d: got (%0d,%0d) %h need (%0d,%0d) %h", k, row_at(k), col_at(k), q_at(k), k / H, k % H, model_win(1'b0, k / H, k % H));
         end
      end
   endtask

   initial begin
      bus.pix_in = '0;
      bus.pix_in_valid = 1'b0;
      bus.win_ready = 1'b0;
      test_reset();
      test_basic();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
